// File: rtl/rv_periph_pkg.sv
// rv_periph_pkg
//   Definitions shared by the memory-mapped peripherals of the RV32I SoC:
//   bus field widths, the bus request bundle, the GPI register offsets and
//   a helper that decides whether a byte address selects a given word
//   register.
package rv_periph_pkg;

    localparam int BUS_AW = 5;
    localparam int BUS_DW = 32;

    typedef logic [BUS_AW-1:0] bus_addr_t;
    typedef logic [BUS_DW-1:0] bus_data_t;

    // One bus access as seen by a peripheral.
    typedef struct packed {
        logic      ce;
        logic      wr_en;
        bus_addr_t addr;
        bus_data_t wdata;
    } bus_req_t;

    // GPI register byte offsets.
    localparam bus_addr_t GPI_CFG  = 5'h00;
    localparam bus_addr_t GPI_IDR  = 5'h04;
    localparam bus_addr_t GPI_EN   = 5'h08;
    localparam bus_addr_t GPI_PEND = 5'h0C;
    localparam bus_addr_t GPI_RAW  = 5'h10;

    // Registers are word aligned, so byte-lane bits [1:0] never take part
    // in the decode.
    function automatic logic reg_sel(input bus_addr_t a, input bus_addr_t off);
        return a[BUS_AW-1:2] == off[BUS_AW-1:2];
    endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// gpi_debounce_bit
//   Conditions one asynchronous input pin: two-flop synchroniser followed by
//   a counting debouncer. The debounced value only follows the synchronised
//   value after it has disagreed for neff consecutive cycles.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   pin        : asynchronous external input
//   cnt_clr    : clears the debounce counter (debounced value is kept)
//   neff       : effective threshold, must be >= 1
//   sync       : second synchroniser stage (pre-debounce value)
//   stable     : debounced value
//   rise, fall : single-cycle pulses, high in the cycle whose rising edge
//                updates stable 0->1 / 1->0
module gpi_debounce_bit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pin,
    input  logic             cnt_clr,
    input  logic [CNT_W-1:0] neff,
    output logic             sync,
    output logic             stable,
    output logic             rise,
    output logic             fall
);

    logic             meta_reg;
    logic             sync_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W:0]   cnt_inc;
    logic             differ;
    logic             hit;

    // One extra bit keeps the compare exact even at the top of the range.
    assign cnt_inc = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
    assign differ  = sync_reg != stable_reg;
    // A counter clear in the same cycle also cancels the update, so the
    // edge pulses stay consistent with what stable actually does.
    assign hit     = !cnt_clr && differ && (cnt_inc >= {1'b0, neff});

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg   <= 1'b0;
            sync_reg   <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            meta_reg <= pin;
            sync_reg <= meta_reg;
            if (cnt_clr || !differ) begin
                cnt_reg <= '0;
            end else if (hit) begin
                stable_reg <= sync_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_inc[CNT_W-1:0];
            end
        end
    end

    assign sync   = sync_reg;
    assign stable = stable_reg;
    assign rise   = hit &  sync_reg;
    assign fall   = hit & ~sync_reg;

endmodule

// File: rtl/gpi_input_ctrl.sv
// gpi_input_ctrl
//   Bus-attached conditioner for the general-purpose input port. Each pin is
//   synchronised and debounced; edges of the debounced value are latched into
//   write-1-to-clear pending flags and a registered level interrupt is raised
//   while any enabled flag is pending.
// Registers (byte offsets, bits [1:0] ignored):
//   0x00 CFG  RW    [CNT_W-1:0] debounce threshold (0 behaves as 1)
//   0x04 IDR  RO    [WIDTH-1:0] debounced value
//   0x08 EN   RW    [WIDTH-1:0] rise enables, [2*WIDTH-1:WIDTH] fall enables
//   0x0C PEND R/W1C same layout as EN
//   0x10 RAW  RO    synchronised, pre-debounce value
//   others read 0, writes ignored
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   ce, wr_en  : bus select and direction (1 = write)
//   addr, wdata: bus address and write data
//   rdata      : combinational read data, 0 unless ce & ~wr_en
//   InPort     : asynchronous external pins
//   irq        : level interrupt, active-high
module gpi_input_ctrl
    import rv_periph_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] DB_DEFAULT = 16'd1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             wr_en,
    input  logic [4:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] InPort,
    output logic             irq
);

    bus_req_t           req;
    logic               wr_acc;
    logic               cfg_wr;
    logic               en_wr;
    logic               pend_wr;

    logic [CNT_W-1:0]   cfg_reg;
    logic [2*WIDTH-1:0] en_reg;
    logic [2*WIDTH-1:0] pend_reg;
    logic [2*WIDTH-1:0] pend_next;
    logic [2*WIDTH-1:0] pend_clr;
    logic               irq_reg;
    logic [CNT_W-1:0]   neff;

    logic [WIDTH-1:0]   sync_vec;
    logic [WIDTH-1:0]   stable_vec;
    logic [WIDTH-1:0]   rise_vec;
    logic [WIDTH-1:0]   fall_vec;

    // Byte-lane address bits and the upper write-data bits carry no meaning
    // here; folding them keeps the whole bus visibly consumed.
    logic               unused_bus;
    assign unused_bus = ^{req.addr[1:0], req.wdata};

    assign req     = '{ce: ce, wr_en: wr_en, addr: addr, wdata: wdata};
    assign wr_acc  = req.ce && req.wr_en;
    assign cfg_wr  = wr_acc && reg_sel(req.addr, GPI_CFG);
    assign en_wr   = wr_acc && reg_sel(req.addr, GPI_EN);
    assign pend_wr = wr_acc && reg_sel(req.addr, GPI_PEND);

    // A threshold of 0 would never let the counter match; treat it as 1.
    assign neff = (cfg_reg == '0) ? CNT_W'(1) : cfg_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            gpi_debounce_bit #(
                .CNT_W(CNT_W)
            ) u_db (
                .clk    (clk),
                .reset  (reset),
                .pin    (InPort[gi]),
                .cnt_clr(cfg_wr),
                .neff   (neff),
                .sync   (sync_vec[gi]),
                .stable (stable_vec[gi]),
                .rise   (rise_vec[gi]),
                .fall   (fall_vec[gi])
            );
        end
    endgenerate

    // Clear first, then OR in new edges: a set in the same cycle as a
    // write-1-to-clear of that bit survives.
    assign pend_clr  = pend_wr ? req.wdata[2*WIDTH-1:0] : '0;
    assign pend_next = (pend_reg & ~pend_clr) | ({fall_vec, rise_vec} & en_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_reg  <= DB_DEFAULT;
            en_reg   <= '0;
            pend_reg <= '0;
            irq_reg  <= 1'b0;
        end else begin
            if (cfg_wr) begin
                cfg_reg <= req.wdata[CNT_W-1:0];
            end
            if (en_wr) begin
                en_reg <= req.wdata[2*WIDTH-1:0];
            end
            pend_reg <= pend_next;
            irq_reg  <= |(pend_reg & en_reg);
        end
    end

    assign irq = irq_reg;

    always_comb begin
        rdata = '0;
        if (req.ce && !req.wr_en) begin
            if (reg_sel(req.addr, GPI_CFG)) begin
                rdata = 32'(cfg_reg);
            end else if (reg_sel(req.addr, GPI_IDR)) begin
                rdata = 32'(stable_vec);
            end else if (reg_sel(req.addr, GPI_EN)) begin
                rdata = 32'(en_reg);
            end else if (reg_sel(req.addr, GPI_PEND)) begin
                rdata = 32'(pend_reg);
            end else if (reg_sel(req.addr, GPI_RAW)) begin
                rdata = 32'(sync_vec);
            end
        end
    end

endmodule

// File: tb/tb_gpi_input_ctrl.sv
// tb_gpi_input_ctrl
//   Scoreboard bench for gpi_input_ctrl. Directed phase pushes hand-derived
//   constants, random phase pushes values from a pin-level reference model.
//   A monitor pops one expectation per read cycle and also tracks irq.
module tb_gpi_input_ctrl;
    import rv_periph_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        wr_en;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  InPort;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] exp;
    } rd_exp_t;
    rd_exp_t sb[$];

    always #5 clk = ~clk;

    gpi_input_ctrl #(
        .WIDTH(4),
        .CNT_W(16),
        .DB_DEFAULT(16'd1000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .wr_en (wr_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .InPort(InPort),
        .irq   (irq)
    );

    // ---------------- reference model ----------------
    // Each pin: value seen two clocks late; debounced value flips once that
    // delayed value has disagreed with it for neff consecutive clocks.
    logic [15:0] m_cfg   = 16'd1000;
    logic [3:0]  m_sync1 = '0;
    logic [3:0]  m_sync2 = '0;
    logic [3:0]  m_stab  = '0;
    int          m_run[4] = '{0, 0, 0, 0};
    logic [7:0]  m_en    = '0;
    logic [7:0]  m_pend  = '0;
    logic        m_irq   = 1'b0;

    always @(posedge clk) begin : model
        int         neff;
        logic [3:0] rise, fall;
        logic [7:0] pend;
        logic       new_irq;
        logic       is_wr;
        if (reset) begin
            m_cfg = 16'd1000; m_sync1 = '0; m_sync2 = '0; m_stab = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_en = '0; m_pend = '0; m_irq = 1'b0;
        end else begin
            is_wr   = ce && wr_en;
            neff    = (m_cfg == 16'd0) ? 1 : int'(m_cfg);
            new_irq = |(m_pend & m_en);
            rise = '0; fall = '0;
            for (int i = 0; i < 4; i++) begin
                if (is_wr && addr[4:2] == 3'd0) begin
                    m_run[i] = 0;
                end else if (m_sync2[i] != m_stab[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= neff) begin
                        m_stab[i] = m_sync2[i];
                        if (m_stab[i]) rise[i] = 1'b1; else fall[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_sync2 = m_sync1;
            m_sync1 = InPort;
            pend = m_pend;
            if (is_wr && addr[4:2] == 3'd3) pend = pend & ~wdata[7:0];
            pend = pend | ({fall, rise} & m_en);
            if (is_wr && addr[4:2] == 3'd2) m_en = wdata[7:0];
            if (is_wr && addr[4:2] == 3'd0) m_cfg = wdata[15:0];
            m_pend = pend;
            m_irq  = new_irq;
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return {16'd0, m_cfg};
            3'd1:    return {28'd0, m_stab};
            3'd2:    return {24'd0, m_en};
            3'd3:    return {24'd0, m_pend};
            3'd4:    return {28'd0, m_sync2};
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        rd_exp_t e;
        forever begin
            @(negedge clk);
            #1;
            chk("irq_model", {31'd0, irq}, {31'd0, m_irq});
            if (ce && !wr_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=read required=no_read t=%0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("rd@%02h", e.a), rdata, e.exp);
                end
            end else begin
                chk("rdata_idle", rdata, 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic rd(input logic [4:0] a, input logic [31:0] exp);
        ce = 1'b1; wr_en = 1'b0; addr = a; wdata = '0;
        sb.push_back('{a: a, exp: exp});
        @(negedge clk);
        ce = 1'b0;
    endtask

    task automatic rdm(input logic [4:0] a);
        rd(a, model_read(a));
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        ce = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        ce = 1'b0; wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [4:0] ro_addrs[5];
        int         r;
        ro_addrs = '{GPI_IDR, GPI_RAW, 5'h14, 5'h18, 5'h1C};
        ce = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
        InPort = 4'hF; reset = 1'b1;
        idle(4);
        chk("irq_in_reset", {31'd0, irq}, 32'd0);
        reset = 1'b0;

        // Reset state with pins held high.
        rd(GPI_CFG, 32'd1000);
        rd(GPI_IDR, 32'd0);
        rd(GPI_EN, 32'd0);
        rd(GPI_PEND, 32'd0);
        rd(GPI_RAW, 32'hF);
        chk("irq_after_reset", {31'd0, irq}, 32'd0);

        // Debounce timing, CFG=3.
        InPort = 4'h0;
        wr(GPI_CFG, 32'd3);
        idle(6);
        wr(GPI_EN, 32'h01);
        InPort = 4'h1;
        idle(1);
        rd(GPI_IDR, 32'h0);
        rd(GPI_IDR, 32'h0);
        rd(GPI_IDR, 32'h0);
        rd(GPI_IDR, 32'h0);
        chk("irq_before_pend", {31'd0, irq}, 32'd0);
        rd(GPI_IDR, 32'h1);
        chk("irq_after_pend", {31'd0, irq}, 32'd1);
        rd(GPI_PEND, 32'h01);

        // W1C of the last pending bit drops irq one cycle after the write edge.
        wr(GPI_PEND, 32'hFF);
        chk("irq_hold_after_w1c", {31'd0, irq}, 32'd1);
        idle(1);
        chk("irq_drop_after_w1c", {31'd0, irq}, 32'd0);
        rd(GPI_PEND, 32'h0);

        // Glitch of 2 cycles on bit 1 is rejected.
        wr(GPI_EN, 32'h02);
        InPort = 4'h3;
        idle(2);
        InPort = 4'h1;
        idle(8);
        rd(GPI_IDR, 32'h1);
        rd(GPI_PEND, 32'h0);
        chk("irq_glitch", {31'd0, irq}, 32'd0);

        // W1C and set/clear race.
        wr(GPI_EN, 32'h11);
        InPort = 4'h0;
        idle(8);
        rd(GPI_PEND, 32'h10);
        InPort = 4'h1;
        idle(8);
        rd(GPI_PEND, 32'h11);
        wr(GPI_PEND, 32'h01);
        rd(GPI_PEND, 32'h10);
        InPort = 4'h0;
        idle(4);
        wr(GPI_PEND, 32'h10);
        rd(GPI_PEND, 32'h10);

        // Fall edges with CFG=0.
        InPort = 4'hF;
        idle(8);
        wr(GPI_CFG, 32'd0);
        wr(GPI_EN, 32'hF0);
        wr(GPI_PEND, 32'hFF);
        idle(2);
        rd(GPI_IDR, 32'hF);
        InPort = 4'h0;
        idle(1);
        rd(GPI_IDR, 32'hF);
        rd(GPI_IDR, 32'hF);
        rd(GPI_IDR, 32'h0);
        chk("irq_fall", {31'd0, irq}, 32'd1);
        rd(GPI_PEND, 32'hF0);

        // Map edges.
        rd(5'h14, 32'd0);
        wr(5'h14, 32'hFFFF_FFFF);
        rd(GPI_CFG, 32'd0);
        rd(GPI_EN, 32'hF0);
        rd(GPI_PEND, 32'hF0);
        wr(GPI_CFG, 32'hFFFF_FFFF);
        rd(GPI_CFG, 32'h0000_FFFF);
        rd(5'h1C, 32'd0);
        rd(5'h0B, 32'hF0);
        wr(GPI_CFG, 32'd2);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) InPort = 4'($urandom);
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
                wr(GPI_CFG, 32'($urandom_range(0, 4)));
            end else if (r < 8) begin
                wr(GPI_CFG, 32'($urandom_range(0, 4)));
            end else if (r < 14) begin
                wr(GPI_EN, $urandom);
            end else if (r < 22) begin
                wr(GPI_PEND, $urandom);
            end else if (r < 26) begin
                wr(ro_addrs[$urandom_range(0, 4)], $urandom);
            end else begin
                rdm(5'($urandom_range(0, 31)));
            end
        end

        idle(3);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
